// File: rtl/cache_data_ram.sv
// cache_data_ram
//   True dual-port cache line store. Each port can write individual bytes of
//   a line and read a whole line. After reset, the FSM clears every entry
//   (one entry per cycle) before it accepts port traffic. Reads are
//   write-first: a read returns the line after all writes from both ports in
//   that cycle have been merged. When both ports write the same byte of the
//   same line, port A's byte wins.
//
//   Optional build macro CACHE_DATA_RAM_OUTREG_EN adds a second output
//   register per port, which gives 2-cycle read latency. The extra stage is
//   cleared by reset and loads every cycle.
//
// Ports
//   clk                  single clock, rising edge
//   rst                  synchronous active-high reset
//   init_done            high once the clear sweep has finished
//   ena / enb            read enables; the read data holds while low
//   wea / web            byte write enables, DATA_W/8 bits
//   addra / addrb        line index, ADDR_W bits
//   dina / dinb          write data, DATA_W bits
//   douta / doutb        read data, DATA_W bits
module cache_data_ram #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  ena,
  input  logic [DATA_W/8-1:0]   wea,
  input  logic [ADDR_W-1:0]     addra,
  input  logic [DATA_W-1:0]     dina,
  output logic [DATA_W-1:0]     douta,
  input  logic                  enb,
  input  logic [DATA_W/8-1:0]   web,
  input  logic [ADDR_W-1:0]     addrb,
  input  logic [DATA_W-1:0]     dinb,
  output logic [DATA_W-1:0]     doutb
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  // state | meaning
  // INIT  | clearing entry[cnt_q] each cycle; port inputs ignored, outputs 0
  // READY | normal dual-port operation
  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                init_done_d;
  logic                sweep_we;
  logic                port_we;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   fwd_a, fwd_b;
  logic [DATA_W-1:0]   douta_r, doutb_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      init_done <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = 1'b0;
    sweep_we    = 1'b0;
    port_we     = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d     = ST_READY;
          init_done_d = 1'b1;
        end
      end
      ST_READY: begin
        port_we     = 1'b1;
        init_done_d = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Port B's byte writes are issued before port A's, so on a same-address,
  // same-byte collision port A's nonblocking assignment lands last and wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (sweep_we) mem[cnt_q] <= '0;
      if (port_we) begin
        for (int i = 0; i < NB; i++) begin
          if (web[i]) mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
          if (wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
        end
      end
    end
  end

  // Write-first view of each port's read line: stored value, then port B
  // bytes, then port A bytes, matching the collision priority above.
  always_comb begin
    fwd_a = mem[addra];
    fwd_b = mem[addrb];
    for (int i = 0; i < NB; i++) begin
      if (web[i])                     fwd_b[8*i +: 8] = dinb[8*i +: 8];
      if (wea[i] && (addra == addrb)) fwd_b[8*i +: 8] = dina[8*i +: 8];
      if (web[i] && (addrb == addra)) fwd_a[8*i +: 8] = dinb[8*i +: 8];
      if (wea[i])                     fwd_a[8*i +: 8] = dina[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_INIT)) begin
      douta_r <= '0;
      doutb_r <= '0;
    end else begin
      if (ena) douta_r <= fwd_a;
      if (enb) doutb_r <= fwd_b;
    end
  end

`ifdef CACHE_DATA_RAM_OUTREG_EN
  logic [DATA_W-1:0] douta_q2, doutb_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      douta_q2 <= '0;
      doutb_q2 <= '0;
    end else begin
      douta_q2 <= douta_r;
      doutb_q2 <= doutb_r;
    end
  end

  assign douta = douta_q2;
  assign doutb = doutb_q2;
`else
  assign douta = douta_r;
  assign doutb = doutb_r;
`endif

endmodule

// File: tb/tb_cache_data_ram.sv
module tb_cache_data_ram;

`ifdef CACHE_DATA_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        init_done;
  logic        ena, enb;
  logic [3:0]  wea, web;
  logic [3:0]  addra, addrb;
  logic [31:0] dina, dinb;
  logic [31:0] douta, doutb;

  int errors;
  int checks;

  cache_data_ram #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .init_done (init_done),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .douta     (douta),
    .enb       (enb),
    .web       (web),
    .addrb     (addrb),
    .dinb      (dinb),
    .doutb     (doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ena = 1'b0; enb = 1'b0;
    wea = 4'h0; web = 4'h0;
    addra = 4'h0; addrb = 4'h0;
    dina = 32'h0; dinb = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (douta !== 32'h0 || doutb !== 32'h0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: douta=%h doutb=%h init_done=%b, want 0 0 0", douta, doutb, init_done);
    end
    for (int k = 1; k < 16; k++) begin
      tick();
      checks++;
      if (init_done !== 1'b0) begin
        errors++;
        $display("FAIL sweep_low cycle %0d: init_done=%b, want 0", k, init_done);
      end
    end
    tick();
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL sweep_done: init_done=%b, want 1 on cycle 17", init_done);
    end
    for (int k = 0; k < 16; k++) begin
      ena = 1'b1; enb = 1'b1;
      addra = 4'(k); addrb = 4'(15 - k);
      tick();
      repeat (LAT - 1) tick();
      checks++;
      if (douta !== 32'h0 || doutb !== 32'h0) begin
        errors++;
        $display("FAIL cleared_read addr %0d: douta=%h doutb=%h, want 0", k, douta, doutb);
      end
    end
    idle_inputs();
  endtask

  task automatic test_byte_write();
    logic [31:0] s [0:3];
    ena = 1'b1; addra = 4'd3; wea = 4'hF; dina = 32'hDEADBEEF;
    tick();
    s[0] = douta;
    wea = 4'h1; dina = 32'h000000AA;
    tick();
    s[1] = douta;
    ena = 1'b0; wea = 4'h0; dina = 32'h0;
    tick();
    s[2] = douta;
    checks++;
    if (s[LAT-1] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL full_write_read: douta=%h, want deadbeef", s[LAT-1]);
    end
    checks++;
    if (s[LAT] !== 32'hDEADBEAA) begin
      errors++;
      $display("FAIL byte_write_read: douta=%h, want deadbeaa", s[LAT]);
    end
    addra = 4'd5;
    repeat (LAT + 1) tick();
    checks++;
    if (douta !== 32'hDEADBEAA) begin
      errors++;
      $display("FAIL read_hold: douta=%h, want deadbeaa", douta);
    end
    idle_inputs();
  endtask

  task automatic test_collision();
    ena = 1'b1; addra = 4'd5; wea = 4'b0011; dina = 32'h11111111;
    addrb = 4'd5; web = 4'b0110; dinb = 32'h22222222;
    tick();
    wea = 4'h0; web = 4'h0;
    repeat (LAT - 1) tick();
    checks++;
    if (douta !== 32'h00221111) begin
      errors++;
      $display("FAIL collision_fwd: douta=%h, want 00221111", douta);
    end
    ena = 1'b0; enb = 1'b1; addrb = 4'd5;
    tick();
    repeat (LAT - 1) tick();
    checks++;
    if (doutb !== 32'h00221111) begin
      errors++;
      $display("FAIL collision_stored: doutb=%h, want 00221111", doutb);
    end
    idle_inputs();
  endtask

  task automatic test_cross_port();
    ena = 1'b1; addra = 4'd7;
    enb = 1'b1; addrb = 4'd7; web = 4'hF; dinb = 32'hCAFEF00D;
    tick();
    web = 4'h0;
    repeat (LAT - 1) tick();
    checks++;
    if (douta !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL cross_fwd_a: douta=%h, want cafef00d", douta);
    end
    checks++;
    if (doutb !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL cross_fwd_b: doutb=%h, want cafef00d", doutb);
    end
    ena = 1'b0; enb = 1'b0;
    addra = 4'd2; wea = 4'hF; dina = 32'h12345678;
    addrb = 4'd9; web = 4'hF; dinb = 32'h9ABCDEF0;
    tick();
    wea = 4'h0; web = 4'h0;
    ena = 1'b1; addra = 4'd9;
    enb = 1'b1; addrb = 4'd2;
    tick();
    repeat (LAT - 1) tick();
    checks++;
    if (douta !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL dual_write_b: douta=%h, want 9abcdef0", douta);
    end
    checks++;
    if (doutb !== 32'h12345678) begin
      errors++;
      $display("FAIL dual_write_a: doutb=%h, want 12345678", doutb);
    end
    idle_inputs();
  endtask

  task automatic test_reset_midsweep();
    int cnt;
    int bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (douta !== 32'h0 || doutb !== 32'h0 || init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_clears_out: douta=%h doutb=%h init_done=%b, want 0 0 0", douta, doutb, init_done);
    end
    repeat (8) tick();
    ena = 1'b1; addra = 4'd3; wea = 4'hF; dina = 32'h55555555;
    enb = 1'b1; addrb = 4'd9; web = 4'hF; dinb = 32'h66666666;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    bad = 0;
    while (init_done !== 1'b1 && cnt < 40) begin
      if (douta !== 32'h0 || doutb !== 32'h0) bad++;
      tick();
      cnt++;
    end
    idle_inputs();
    checks++;
    if (cnt !== 16) begin
      errors++;
      $display("FAIL midsweep_restart: init_done after %0d cycles, want 16", cnt);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL init_outputs: %0d cycles with nonzero output, want 0", bad);
    end
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      ena = 1'b1; enb = 1'b1;
      addra = 4'(k); addrb = 4'(k);
      tick();
      repeat (LAT - 1) tick();
      if (douta !== 32'h0 || doutb !== 32'h0) begin
        bad++;
        $display("FAIL swept_entry %0d: douta=%h doutb=%h, want 0", k, douta, doutb);
      end
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL swept_contents: %0d nonzero entries, want 0", bad);
    end
    idle_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    test_reset();
    test_byte_write();
    test_collision();
    test_cross_port();
    test_reset_midsweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
